// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
//   OWNER_M0 / OWNER_M1 : encodings of the "last granted master" register
//   DEFAULT_MAX_BURST   : default burst limit before the other master is forced in
//   cnt_width()         : minimum burst-counter width able to hold a given MAX_BURST
package dmem_arb_pkg;

  localparam logic OWNER_M0 = 1'b0;
  localparam logic OWNER_M1 = 1'b1;

  localparam int DEFAULT_MAX_BURST = 4;

  // Smallest w such that 2**w > max_burst, i.e. the counter can hold max_burst.
  function automatic int cnt_width(input int max_burst);
    int w;
    w = 1;
    while ((1 << w) <= max_burst) w++;
    return w;
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Pure combinational grant decision for the two-master data-memory arbiter.
// Ports:
//   req0, req1  : request from master 0 / master 1 (already qualified by reset)
//   owner       : master granted most recently (OWNER_M0 / OWNER_M1)
//   cnt_at_max  : owner has used up its burst allowance
//   gnt0, gnt1  : one-hot (or zero) grant for this cycle
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic owner,
  input  logic cnt_at_max,
  output logic gnt0,
  output logic gnt1
);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && req1) begin
      // Contention: the owner keeps the port until its burst is spent,
      // then the waiting master takes over.
      if (cnt_at_max) begin
        gnt0 = (owner == OWNER_M1);
        gnt1 = (owner == OWNER_M0);
      end else begin
        gnt0 = (owner == OWNER_M0);
        gnt1 = (owner == OWNER_M1);
      end
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of the single-port data memory
// (sync write, async read). Master 0 is the CPU load/store path,
// master 1 the DMA/debug port. At most one access is granted per cycle;
// a burst counter bounds how long one master can hold the port while the
// other waits. Read data returns registered, one cycle after the grant.
//
// Handshake (both masters): a master raises mX_req with mX_we/mX_addr/
// mX_wdata stable and keeps them stable until mX_gnt is seen high in the
// same cycle; that cycle is the transfer. After a grant the master may
// change or drop its request freely. A request dropped before its grant
// is simply never performed. Reads return mX_rvalid/mX_rdata one cycle
// after their grant; writes commit at the clock edge ending the grant.
//
// Ports:
//   clk, rst_n                    : clock, async active-low reset
//   mX_req/we/addr/wdata          : master X request
//   mX_gnt                        : master X accepted this cycle (combinational)
//   mX_rvalid/rdata               : master X registered read return
//   mem_MemRead/MemWrite/Addr/WriteData, mem_ReadData : data memory port
//   dbg_owner, dbg_cnt            : arbitration state (last owner, burst count)
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MAX_BURST = DEFAULT_MAX_BURST,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             m0_req,
  input  logic             m0_we,
  input  logic [31:0]      m0_addr,
  input  logic [31:0]      m0_wdata,
  output logic             m0_gnt,
  output logic             m0_rvalid,
  output logic [31:0]      m0_rdata,
  input  logic             m1_req,
  input  logic             m1_we,
  input  logic [31:0]      m1_addr,
  input  logic [31:0]      m1_wdata,
  output logic             m1_gnt,
  output logic             m1_rvalid,
  output logic [31:0]      m1_rdata,
  output logic             mem_MemRead,
  output logic             mem_MemWrite,
  output logic [31:0]      mem_Addr,
  output logic [31:0]      mem_WriteData,
  input  logic [31:0]      mem_ReadData,
  output logic             dbg_owner,
  output logic [CNT_W-1:0] dbg_cnt
);

  if (cnt_width(MAX_BURST) > CNT_W) begin : g_bad_cnt_w
    $error("dmem_arbiter: CNT_W too small to hold MAX_BURST");
  end

  logic             owner;
  logic [CNT_W-1:0] cnt;
  logic             cnt_at_max;
  logic             req0_q;
  logic             req1_q;
  logic             gnt0;
  logic             gnt1;
  logic             gnt_any;
  logic             gnt_id;
  logic             gnt_we;

  assign cnt_at_max = (cnt == CNT_W'(MAX_BURST));

  // Gating requests with rst_n keeps every grant and memory enable low for
  // the whole time reset is asserted, including a grant already in flight.
  assign req0_q = m0_req & rst_n;
  assign req1_q = m1_req & rst_n;

  dmem_arb_pick u_pick (
    .req0       (req0_q),
    .req1       (req1_q),
    .owner      (owner),
    .cnt_at_max (cnt_at_max),
    .gnt0       (gnt0),
    .gnt1       (gnt1)
  );

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign gnt_any   = gnt0 | gnt1;
  assign gnt_id    = gnt1 ? OWNER_M1 : OWNER_M0;
  assign dbg_owner = owner;
  assign dbg_cnt   = cnt;

  // Memory port mux; everything is zero when nobody is granted.
  always_comb begin
    gnt_we        = 1'b0;
    mem_Addr      = 32'h0;
    mem_WriteData = 32'h0;
    if (gnt0) begin
      gnt_we        = m0_we;
      mem_Addr      = m0_addr;
      mem_WriteData = m0_wdata;
    end else if (gnt1) begin
      gnt_we        = m1_we;
      mem_Addr      = m1_addr;
      mem_WriteData = m1_wdata;
    end
  end

  assign mem_MemWrite = gnt_any & gnt_we;
  assign mem_MemRead  = gnt_any & ~gnt_we;

  // Burst tracking: count consecutive grants to the same master,
  // saturating at MAX_BURST; a switch of master restarts the count at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner <= OWNER_M0;
      cnt   <= '0;
    end else if (gnt_any) begin
      if (gnt_id == owner) begin
        if (!cnt_at_max) cnt <= cnt + CNT_W'(1);
      end else begin
        owner <= gnt_id;
        cnt   <= CNT_W'(1);
      end
    end
  end

  // Registered read return; rdata holds between reads of its own master.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rvalid <= 1'b0;
      m0_rdata  <= 32'h0;
      m1_rvalid <= 1'b0;
      m1_rdata  <= 32'h0;
    end else begin
      m0_rvalid <= gnt0 & ~m0_we;
      m1_rvalid <= gnt1 & ~m1_we;
      if (gnt0 && !m0_we) m0_rdata <= mem_ReadData;
      if (gnt1 && !m1_we) m1_rdata <= mem_ReadData;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-master arbiter in front of the single-port data memory (sync write, async read, word-indexed by Addr[9:2]).
- Master 0 is the CPU load/store path; master 1 is the DMA/debug port.
- Grants at most one access per cycle, bounds starvation with a burst counter, and returns registered read data one cycle after grant.

Parameters:
- MAX_BURST, 4, max consecutive grants to one master while the other is requesting (legal range 1..15).
- CNT_W, 4, burst counter width; must hold MAX_BURST.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- m0_req  in  1  master 0 access request, held until granted
- m0_we  in  1  master 0 write (1) / read (0)
- m0_addr  in  32  master 0 byte address
- m0_wdata  in  32  master 0 write data
- m0_gnt  out  1  master 0 access accepted this cycle (combinational)
- m0_rvalid  out  1  master 0 read data valid (registered pulse)
- m0_rdata  out  32  master 0 read data (registered)
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as master 0, for master 1
- mem_MemRead  out  1  to datamem MemRead
- mem_MemWrite  out  1  to datamem MemWrite
- mem_Addr  out  32  to datamem Addr
- mem_WriteData  out  32  to datamem WriteData
- mem_ReadData  in  32  from datamem ReadData

Behaviour:
- Reset (async, rst_n=0):
  - owner=0, cnt=0, m0/m1_rvalid=0, m0/m1_rdata=0.
  - All gnt, mem_MemRead and mem_MemWrite forced 0 while rst_n=0.
- State: owner (1 bit, last granted master); cnt (CNT_W, consecutive grants to owner).
- Grant decision (combinational, each cycle):
  - Neither requests: no grant; owner and cnt unchanged.
  - Only mX requests: gnt_X=1.
  - Both request, cnt<MAX_BURST: owner is granted.
  - Both request, cnt==MAX_BURST: the non-owner is granted.
- Update on posedge when some gnt_X=1:
  - X==owner: cnt=min(cnt+1, MAX_BURST).
  - X!=owner: owner=X, cnt=1.
- Saturation: cnt saturates at MAX_BURST; it never wraps.
- Memory drive:
  - Granted master's addr/wdata are muxed to mem_Addr and mem_WriteData.
  - mem_MemWrite = gnt & we; mem_MemRead = gnt & ~we.
  - With no grant: mem_Addr=0, mem_WriteData=0, both enables 0.
- Write latency: the write commits at the posedge ending the grant cycle.
- Read latency 1:
  - On the posedge ending a read grant to X, mX_rdata<=mem_ReadData and mX_rvalid<=1.
  - The next cycle has mX_rvalid=0 unless X is read-granted again.
  - The non-granted master's rdata holds its value.
  - Write grants never assert rvalid.
- Back-to-back: one access per cycle sustained. No bubble on owner switch.
- Read-after-write to the same address in consecutive cycles returns the new data.
- Request rules:
  - Req must stay stable (addr/we/wdata) until gnt. A request dropped before gnt is lost silently; no error.
  - Masters may change req/addr combinationally after gnt; there is no pipelined request queue.
- Reset mid-operation: a read granted in the cycle reset asserts produces no rvalid; a write in that cycle is not performed. Memory contents are not cleared.
- Addresses are passed unmodified; alignment and the range above Addr[9:2] are the memory's concern.

Decomposition:
- Package dmem_arb_pkg:
  - constants OWNER_M0=1'b0, OWNER_M1=1'b1
  - default MAX_BURST=4
  - function for CNT_W sizing
- Sub-module dmem_arb_pick: pure combinational grant decision (req0, req1, owner, cnt_at_max) -> gnt0, gnt1. The top holds registers, the mux and read-return.

Test Plan:
- Reset: hold rst_n=0 with both reqs high -> gnt=0, mem enables=0, rvalid=0, rdata=0. Release -> m0 granted first (owner=0, cnt=0).
- Single master: m0 writes 0xDEADBEEF to 0x10, next cycle reads 0x10 -> m0_rvalid=1 one cycle after the read grant, m0_rdata=0xDEADBEEF; m1_rvalid stays 0.
- Fairness, MAX_BURST=4: both hold reads continuously -> grant pattern m0 x4, m1 x4, m0 x4. Each rvalid is on the correct master with the correct data.
- Idle switch: m1 alone reads 0x20 (preloaded 0x12345678) -> granted immediately, m1_rdata=0x12345678 next cycle, owner=1, cnt=1.
- Write priority collision: m0 writes 0x55 to 0x40 while m1 reads 0x40 -> m0 granted first (owner=0). m1's read lands the next cycle and returns 0x55.
- Async reset mid-burst: assert rst_n low mid-cycle during an m1 read grant -> rvalid=0 immediately. After release owner=0, and the interrupted read never returns data.
